// File: rtl/foc_align_seq_if.sv
// Signal bundle between the alignment sequencer and its environment (ADC/encoder side and SVPWM side).
interface foc_align_seq_if;
    logic        calib_done;
    logic        realign;
    logic [15:0] psi_raw;
    logic        psi_valid;
    logic        override;
    logic [15:0] mag_init;
    logic [15:0] phase_init;
    logic [15:0] psi_offset;
    logic        dir_inv;
    logic        initialized;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        output calib_done, realign, psi_raw, psi_valid,
        input  override, mag_init, phase_init, psi_offset, dir_inv,
               initialized, busy, fault, fault_code
    );

    modport slave (
        input  calib_done, realign, psi_raw, psi_valid,
        output override, mag_init, phase_init, psi_offset, dir_inv,
               initialized, busy, fault, fault_code
    );
endinterface

// File: rtl/foc_align_seq.sv
// Rotor alignment: ramp a fixed-angle voltage vector, average the encoder at electrical 0 and 90 deg,
// then publish the mechanical zero offset and rotation direction (or a timeout / no-motion fault).
module foc_align_seq #(
    parameter logic [7:0]  POLEPAIRS   = 8'd4,
    parameter logic [15:0] MAG_TGT     = 16'hD1FE,
    parameter logic [15:0] MAG_STEP    = 16'h0040,
    parameter logic [31:0] SETTLE_TIME = 32'd50000000,
    parameter int          AVG_LOG2    = 4,
    parameter logic [31:0] TIMEOUT     = 32'd1000000,
    parameter logic [15:0] MIN_DELTA   = 16'h0400
) (
    input  logic           clk,
    input  logic           rst,
    foc_align_seq_if.slave io
);
    localparam int AW = 16 + AVG_LOG2;
    localparam int NS = 1 << AVG_LOG2;

    if (AVG_LOG2 < 0 || AVG_LOG2 > 8 || POLEPAIRS == 8'd0) begin : g_bad_param
        $error("foc_align_seq: AVG_LOG2 must be 0..8 and POLEPAIRS nonzero");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_RAMP, S_SETTLE0, S_SAMPLE0, S_SETTLE1, S_SAMPLE1, S_CHECK, S_DONE, S_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          mag_q, mag_d, phase_q, phase_d, ref_q, ref_d;
    logic [15:0]          avg0_q, avg0_d, avg1_q, avg1_d, off_q, off_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [8:0]           nsamp_q, nsamp_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 dir_q, dir_d, init_q, init_d;
    logic [1:0]           fcode_q, fcode_d;

    logic [16:0]          ramp_sum;
    logic [15:0]          mag_sat, diff, ref_new, avg_new, delta, delta_abs;
    logic signed [AW-1:0] acc_new, acc_shr;
    logic                 first_smp, last_smp;

    assign ramp_sum  = {1'b0, mag_q} + {1'b0, MAG_STEP};
    assign mag_sat   = (ramp_sum >= {1'b0, MAG_TGT}) ? MAG_TGT : ramp_sum[15:0];

    // Samples are taken relative to the first one so the average survives the 0xFFFF/0x0000 wrap.
    assign first_smp = (nsamp_q == 9'd0);
    assign last_smp  = (nsamp_q == 9'(NS - 1));
    assign diff      = io.psi_raw - ref_q;
    assign ref_new   = first_smp ? io.psi_raw : ref_q;
    assign acc_new   = first_smp ? '0 : acc_q + AW'(signed'(diff));
    assign acc_shr   = acc_new >>> AVG_LOG2;
    assign avg_new   = ref_new + acc_shr[15:0];

    assign delta     = avg1_q - avg0_q;
    assign delta_abs = delta[15] ? (~delta + 16'd1) : delta;

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        nsamp_d = nsamp_q;
        ref_d   = ref_q;
        acc_d   = acc_q;
        avg0_d  = avg0_q;
        avg1_d  = avg1_q;
        off_d   = off_q;
        dir_d   = dir_q;
        init_d  = init_q;
        fcode_d = fcode_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_RAMP;
                mag_d   = '0;
                phase_d = '0;
                cnt_d   = '0;
            end
            S_RAMP: begin
                if (mag_q == MAG_TGT) begin
                    state_d = S_SETTLE0;
                    cnt_d   = '0;
                end else begin
                    mag_d = mag_sat;
                end
            end
            S_SETTLE0, S_SETTLE1: begin
                if (cnt_q + 32'd1 >= SETTLE_TIME) begin
                    state_d = (state_q == S_SETTLE0) ? S_SAMPLE0 : S_SAMPLE1;
                    cnt_d   = '0;
                    nsamp_d = '0;
                    acc_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SAMPLE0, S_SAMPLE1: begin
                // A sample arriving in the expiring cycle wins over the timeout.
                if (io.psi_valid) begin
                    cnt_d   = '0;
                    ref_d   = ref_new;
                    acc_d   = acc_new;
                    nsamp_d = nsamp_q + 9'd1;
                    if (last_smp) begin
                        if (state_q == S_SAMPLE0) begin
                            avg0_d  = avg_new;
                            phase_d = 16'h4000;
                            state_d = S_SETTLE1;
                        end else begin
                            avg1_d  = avg_new;
                            state_d = S_CHECK;
                        end
                    end
                end else if (cnt_q + 32'd1 >= TIMEOUT) begin
                    state_d = S_FAULT;
                    fcode_d = 2'd1;
                    mag_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CHECK: begin
                mag_d = '0;
                if (delta_abs < MIN_DELTA) begin
                    state_d = S_FAULT;
                    fcode_d = 2'd2;
                end else begin
                    state_d = S_DONE;
                    off_d   = avg0_q;
                    dir_d   = delta[15];
                    init_d  = 1'b1;
                end
            end
            S_DONE, S_FAULT: begin
                if (io.realign) begin
                    state_d = S_RAMP;
                    mag_d   = '0;
                    phase_d = '0;
                    cnt_d   = '0;
                    init_d  = 1'b0;
                    fcode_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing calibration aborts everything but keeps the last good offset/direction.
        if (!io.calib_done) begin
            state_d = S_IDLE;
            mag_d   = '0;
            phase_d = '0;
            cnt_d   = '0;
            init_d  = 1'b0;
            fcode_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            nsamp_q <= '0;
            ref_q   <= '0;
            acc_q   <= '0;
            avg0_q  <= '0;
            avg1_q  <= '0;
            off_q   <= '0;
            dir_q   <= 1'b0;
            init_q  <= 1'b0;
            fcode_q <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            nsamp_q <= nsamp_d;
            ref_q   <= ref_d;
            acc_q   <= acc_d;
            avg0_q  <= avg0_d;
            avg1_q  <= avg1_d;
            off_q   <= off_d;
            dir_q   <= dir_d;
            init_q  <= init_d;
            fcode_q <= fcode_d;
        end
    end

    assign io.busy        = state_q inside {S_RAMP, S_SETTLE0, S_SAMPLE0, S_SETTLE1, S_SAMPLE1, S_CHECK};
    assign io.override    = io.busy || (state_q == S_FAULT);
    assign io.fault       = (state_q == S_FAULT);
    assign io.fault_code  = fcode_q;
    assign io.mag_init    = mag_q;
    assign io.phase_init  = phase_q;
    assign io.psi_offset  = off_q;
    assign io.dir_inv     = dir_q;
    assign io.initialized = init_q;
endmodule

// File: tb/tb_foc_align_seq.sv
// Bench for foc_align_seq: directed and randomized alignment runs scored against a sample-averaging model.
module tb_foc_align_seq;
    localparam int          AVG_LOG2 = 2;
    localparam int          NS       = 4;
    localparam int          SETTLE_I = 10;
    localparam int          TMO_I    = 20;
    localparam logic [15:0] TGT      = 16'hD1FE;
    localparam logic [15:0] STEP     = 16'h0040;
    localparam logic [15:0] MIND     = 16'h0400;
    localparam int          RAMP_STEPS = (int'(TGT) + int'(STEP) - 1) / int'(STEP);

    typedef logic [15:0] smp_t [NS];

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    logic [15:0] exp_off = 16'h0;
    logic        exp_dir = 1'b0;

    foc_align_seq_if bus();

    foc_align_seq #(
        .POLEPAIRS(8'd4), .MAG_TGT(TGT), .MAG_STEP(STEP), .SETTLE_TIME(32'(SETTLE_I)),
        .AVG_LOG2(AVG_LOG2), .TIMEOUT(32'(TMO_I)), .MIN_DELTA(MIND)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Circular mean: reference sample plus floor of the mean signed offset from it.
    function automatic logic [15:0] model_avg(input smp_t s);
        int sum = 0;
        logic signed [15:0] d;
        for (int i = 0; i < NS; i++) begin
            d = s[i] - s[0];
            sum = sum + int'(d);
        end
        return s[0] + 16'(sum >>> AVG_LOG2);
    endfunction

    task automatic hold_junk(input int n, input logic vld);
        for (int i = 0; i < n; i++) begin
            bus.psi_valid = vld;
            bus.psi_raw   = 16'($urandom);
            tick;
        end
        bus.psi_valid = 1'b0;
    endtask

    task automatic feed(input smp_t s);
        for (int i = 0; i < NS; i++) begin
            bus.psi_valid = 1'b1;
            bus.psi_raw   = s[i];
            tick;
        end
        bus.psi_valid = 1'b0;
    endtask

    task automatic ramp_check;
        int k = 0;
        logic bad = 1'b0;
        logic [15:0] exp_m, bad_act, bad_exp;
        bad_act = '0;
        bad_exp = '0;
        forever begin
            exp_m = (k * int'(STEP) >= int'(TGT)) ? TGT : 16'(k * int'(STEP));
            if (bus.mag_init !== exp_m && !bad) begin
                bad = 1'b1; bad_act = bus.mag_init; bad_exp = exp_m;
            end
            if (bus.mag_init === TGT || k > 4000) break;
            tick;
            k++;
        end
        vectors++;
        if (bad || k != RAMP_STEPS) begin
            errors++;
            $display("FAIL ramp: mag_init %h expected %h, steps to target %0d expected %0d", bad_act, bad_exp, k, RAMP_STEPS);
        end
    endtask

    task automatic start_realign;
        bus.realign = 1'b1;
        tick;
        bus.realign = 1'b0;
        vectors++;
        if ({bus.busy, bus.override, bus.fault, bus.fault_code, bus.initialized, bus.mag_init, bus.phase_init}
            !== {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL realign_start: busy/ovr/flt/code/init/mag/phase = %b %b %b %0d %b %h %h, expected 1 1 0 0 0 0000 0000",
                     bus.busy, bus.override, bus.fault, bus.fault_code, bus.initialized, bus.mag_init, bus.phase_init);
        end
    endtask

    task automatic score_result(input smp_t s0, input smp_t s1);
        logic [15:0] a0, a1;
        logic signed [15:0] dl;
        int amag;
        logic [22:0] want, got;
        a0 = model_avg(s0);
        a1 = model_avg(s1);
        dl = a1 - a0;
        amag = (dl < 0) ? -int'(dl) : int'(dl);
        if (amag < int'(MIND)) begin
            want = {1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0};
        end else begin
            want = {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
            exp_off = a0;
            exp_dir = (dl < 0);
        end
        got = {bus.override, bus.busy, bus.fault, bus.fault_code, bus.initialized, bus.mag_init};
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL result_status: ovr/busy/flt/code/init/mag = %h, expected %h (avg0 %h avg1 %h)", got, want, a0, a1);
        end
        vectors++;
        if ({bus.psi_offset, bus.dir_inv} !== {exp_off, exp_dir}) begin
            errors++;
            $display("FAIL result_offset: psi_offset %h dir_inv %b, expected %h %b", bus.psi_offset, bus.dir_inv, exp_off, exp_dir);
        end
    endtask

    task automatic run_both(input smp_t s0, input smp_t s1);
        hold_junk(1 + SETTLE_I, 1'b1);
        feed(s0);
        vectors++;
        if (bus.phase_init !== 16'h4000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL settle1_entry: phase_init %h busy %b, expected 4000 1", bus.phase_init, bus.busy);
        end
        hold_junk(SETTLE_I, 1'b1);
        feed(s1);
        tick;
        score_result(s0, s1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.calib_done = 1'b0;
        bus.realign = 1'b0;
        bus.psi_valid = 1'b0;
        bus.psi_raw = 16'h0;
        tick;
        tick;
        rst = 1'b0;
        vectors++;
        if ({bus.override, bus.mag_init, bus.phase_init, bus.psi_offset, bus.dir_inv, bus.initialized,
             bus.busy, bus.fault, bus.fault_code} !== '0) begin
            errors++;
            $display("FAIL reset: outputs ovr %b mag %h ph %h off %h dir %b init %b busy %b flt %b code %0d, expected all 0",
                     bus.override, bus.mag_init, bus.phase_init, bus.psi_offset, bus.dir_inv, bus.initialized,
                     bus.busy, bus.fault, bus.fault_code);
        end
    endtask

    task automatic test_nominal;
        smp_t s0, s1;
        s0 = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        s1 = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        bus.calib_done = 1'b1;
        tick;
        vectors++;
        if ({bus.busy, bus.override, bus.mag_init, bus.phase_init} !== {1'b1, 1'b1, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL idle_to_ramp: busy %b ovr %b mag %h phase %h, expected 1 1 0000 0000",
                     bus.busy, bus.override, bus.mag_init, bus.phase_init);
        end
        ramp_check;
        run_both(s0, s1);
    endtask

    task automatic test_directed;
        smp_t s0, s1;
        s0 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        s1 = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        start_realign; ramp_check; run_both(s0, s1);
        s0 = '{16'h3000, 16'h3000, 16'h3000, 16'h3000};
        s1 = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        start_realign; ramp_check; run_both(s0, s1);
        s1 = '{16'h3100, 16'h3100, 16'h3100, 16'h3100};
        start_realign; ramp_check; run_both(s0, s1);
    endtask

    task automatic test_timeout;
        start_realign;
        ramp_check;
        hold_junk(1 + SETTLE_I, 1'b0);
        hold_junk(TMO_I - 1, 1'b0);
        vectors++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: fault %b busy %b after %0d idle sample cycles, expected 0 1", bus.fault, bus.busy, TMO_I - 1);
        end
        tick;
        vectors++;
        if ({bus.fault, bus.fault_code, bus.mag_init, bus.override, bus.busy} !== {1'b1, 2'd1, 16'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_fault: fault %b code %0d mag %h ovr %b busy %b, expected 1 1 0000 1 0",
                     bus.fault, bus.fault_code, bus.mag_init, bus.override, bus.busy);
        end
    endtask

    task automatic test_timeout_edge;
        smp_t s0, s1;
        s0 = '{16'h5000, 16'h5004, 16'h4FFC, 16'h5008};
        s1 = '{16'h6000, 16'h6000, 16'h6000, 16'h6000};
        start_realign;
        ramp_check;
        hold_junk(1 + SETTLE_I, 1'b0);
        hold_junk(TMO_I - 1, 1'b0);
        bus.psi_valid = 1'b1;
        bus.psi_raw = s0[0];
        tick;
        bus.psi_valid = 1'b0;
        vectors++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge: fault %b busy %b with sample on expiring cycle, expected 0 1", bus.fault, bus.busy);
        end
        for (int i = 1; i < NS; i++) begin
            bus.psi_valid = 1'b1;
            bus.psi_raw = s0[i];
            tick;
        end
        bus.psi_valid = 1'b0;
        hold_junk(SETTLE_I, 1'b1);
        feed(s1);
        tick;
        score_result(s0, s1);
    endtask

    task automatic test_random;
        smp_t s0, s1;
        logic [15:0] b0, mv;
        for (int n = 0; n < 5; n++) begin
            b0 = 16'($urandom);
            mv = 16'($urandom_range(0, 16'h0C00));
            if ($urandom_range(0, 1) == 1) mv = -mv;
            for (int i = 0; i < NS; i++) begin
                s0[i] = b0 + 16'($urandom_range(0, 64)) - 16'd32;
                s1[i] = b0 + mv + 16'($urandom_range(0, 64)) - 16'd32;
            end
            start_realign;
            ramp_check;
            run_both(s0, s1);
        end
    endtask

    task automatic test_controls;
        smp_t s0;
        s0 = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        bus.calib_done = 1'b0;
        bus.realign = 1'b1;
        tick;
        bus.realign = 1'b0;
        vectors++;
        if ({bus.busy, bus.override, bus.fault, bus.fault_code, bus.initialized, bus.psi_offset, bus.dir_inv}
            !== {1'b0, 1'b0, 1'b0, 2'd0, 1'b0, exp_off, exp_dir}) begin
            errors++;
            $display("FAIL calib_beats_realign: busy %b ovr %b flt %b code %0d init %b off %h dir %b, expected 0 0 0 0 0 %h %b",
                     bus.busy, bus.override, bus.fault, bus.fault_code, bus.initialized, bus.psi_offset, bus.dir_inv, exp_off, exp_dir);
        end
        bus.calib_done = 1'b1;
        tick;
        ramp_check;
        hold_junk(1 + SETTLE_I, 1'b1);
        feed(s0);
        hold_junk(3, 1'b1);
        bus.realign = 1'b1;
        tick;
        bus.realign = 1'b0;
        vectors++;
        if ({bus.busy, bus.phase_init, bus.mag_init} !== {1'b1, 16'h4000, TGT}) begin
            errors++;
            $display("FAIL realign_ignored: busy %b phase %h mag %h, expected 1 4000 %h", bus.busy, bus.phase_init, bus.mag_init, TGT);
        end
        bus.calib_done = 1'b0;
        tick;
        vectors++;
        if ({bus.busy, bus.override, bus.mag_init, bus.initialized, bus.psi_offset, bus.dir_inv}
            !== {1'b0, 1'b0, 16'h0, 1'b0, exp_off, exp_dir}) begin
            errors++;
            $display("FAIL calib_drop: busy %b ovr %b mag %h init %b off %h dir %b, expected 0 0 0000 0 %h %b",
                     bus.busy, bus.override, bus.mag_init, bus.initialized, bus.psi_offset, bus.dir_inv, exp_off, exp_dir);
        end
    endtask

    task automatic test_rst_sample1;
        smp_t s0;
        s0 = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        bus.calib_done = 1'b1;
        tick;
        ramp_check;
        hold_junk(1 + SETTLE_I, 1'b1);
        feed(s0);
        hold_junk(SETTLE_I, 1'b1);
        bus.psi_valid = 1'b1;
        bus.psi_raw = 16'h0900;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.psi_valid = 1'b0;
        exp_off = 16'h0;
        exp_dir = 1'b0;
        vectors++;
        if ({bus.override, bus.mag_init, bus.phase_init, bus.psi_offset, bus.dir_inv, bus.initialized,
             bus.busy, bus.fault, bus.fault_code} !== '0) begin
            errors++;
            $display("FAIL rst_in_sample1: ovr %b mag %h ph %h off %h dir %b init %b busy %b flt %b code %0d, expected all 0",
                     bus.override, bus.mag_init, bus.phase_init, bus.psi_offset, bus.dir_inv, bus.initialized,
                     bus.busy, bus.fault, bus.fault_code);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_directed;
        test_timeout;
        test_timeout_edge;
        test_random;
        test_controls;
        test_rst_sample1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/foc_align_seq.md
FOC_ALIGN_SEQ -- requirements
Module: foc_align_seq

Interface
REQ-001 SHALL have parameter POLEPAIRS, default 8'd4, motor pole-pair count.
REQ-002 SHALL have parameter MAG_TGT, default 16'hD1FE, final alignment voltage magnitude.
REQ-003 SHALL have parameter MAG_STEP, default 16'h0040, magnitude increment per cycle during ramp.
REQ-004 SHALL have parameter SETTLE_TIME, default 32'd50000000, settle cycles per position.
REQ-005 SHALL have parameter AVG_LOG2, default 4, log2 of psi samples averaged per position (range 0..8).
REQ-006 SHALL have parameter TIMEOUT, default 32'd1000000, max cycles between psi_valid pulses while sampling.
REQ-007 SHALL have parameter MIN_DELTA, default 16'h0400, minimum |mechanical movement| between positions.
REQ-008 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-009 SHALL have port calib_done  in  1  ADC calibration complete; enables sequence.
REQ-010 SHALL have port realign  in  1  one-cycle request to rerun alignment from DONE or FAULT.
REQ-011 SHALL have port psi_raw  in  16  raw mechanical angle; psi_valid  in  1  psi_raw qualifier.
REQ-012 SHALL have port override  out  1  high while sequencer drives mag_init/phase_init to SVPWM.
REQ-013 SHALL have port mag_init  out  16  alignment magnitude; phase_init  out  16  alignment electrical angle.
REQ-014 SHALL have port psi_offset  out  16  averaged zero-position mechanical angle; dir_inv  out  1  detected angle inversion.
REQ-015 SHALL have port initialized  out  1; busy  out  1; fault  out  1; fault_code  out  2 (1 timeout, 2 no motion).

Function
REQ-016 SHALL implement states IDLE, RAMP, SETTLE0, SAMPLE0, SETTLE1, SAMPLE1, CHECK, DONE, FAULT.
REQ-017 SHALL go IDLE->RAMP on the first cycle calib_done is high; phase_init=16'h0000, mag_init=0.
REQ-018 SHALL in RAMP add MAG_STEP to mag_init each cycle, saturating at MAG_TGT, then enter SETTLE0 the cycle after mag_init==MAG_TGT.
REQ-019 SHALL in SETTLEx count exactly SETTLE_TIME cycles, then enter SAMPLEx with the sample counter and accumulator cleared.
REQ-020 SHALL in SAMPLEx capture psi_raw on each psi_valid cycle; the first sample is stored as reference r, later samples accumulate signed 16-bit (psi_raw - r) into an accumulator of 16+AVG_LOG2 bits.
REQ-021 SHALL compute a position average as r + (accumulator >>> AVG_LOG2), modulo 2^16, so averages spanning the 16'hFFFF/16'h0000 wrap are correct.
REQ-022 SHALL leave SAMPLEx after 2^AVG_LOG2 accepted samples; SAMPLE0 -> SETTLE1 with phase_init=16'h4000; SAMPLE1 -> CHECK.
REQ-023 SHALL in SAMPLEx enter FAULT with fault_code=1 if TIMEOUT cycles elapse without psi_valid; psi_valid in the expiring cycle is accepted and no fault raised.
REQ-024 SHALL in CHECK (one cycle) form delta = avg1 - avg0 as signed 16-bit; |delta| < MIN_DELTA -> FAULT fault_code=2; else DONE.
REQ-025 SHALL on the CHECK->DONE edge load psi_offset=avg0, dir_inv=delta[15], initialized=1.
REQ-026 SHALL hold override=1 in RAMP..CHECK and FAULT, 0 in IDLE and DONE; busy=1 in RAMP..CHECK only.
REQ-027 SHALL force mag_init=0 in IDLE, DONE and FAULT; fault=1 only in FAULT.
REQ-028 SHALL on realign in DONE or FAULT clear initialized, fault, fault_code and enter RAMP; realign is ignored in other states.
REQ-029 SHALL on calib_done low in any state enter IDLE next cycle, clear initialized/fault/fault_code, retain psi_offset and dir_inv; calib_done low wins over simultaneous realign.

Reset
REQ-030 SHALL on rst high at a clk edge force IDLE, all outputs 0 and all counters/accumulators 0, including mid-sequence.

Verification
REQ-031 SHALL verify nominal: AVG_LOG2=2, SETTLE_TIME=10, psi 0x1000 at pos0, 0x2000 at pos1 -> psi_offset=0x1000, dir_inv=0, initialized=1.
REQ-032 SHALL verify wrap: pos0 samples 0xFFFE,0xFFFF,0x0000,0x0001 -> avg0=0xFFFF (not 0x7FFF), psi_offset=0xFFFF.
REQ-033 SHALL verify inversion: pos0 0x3000, pos1 0x2000 -> dir_inv=1; and no motion: pos1 0x3100 with MIN_DELTA=0x0400 -> fault=1, fault_code=2, mag_init=0.
REQ-034 SHALL verify timeout: TIMEOUT=20, psi_valid stuck low in SAMPLE0 -> fault_code=1 on cycle 20; pulse at cycle 20 instead -> no fault.
REQ-035 SHALL verify ramp: MAG_STEP=0x0040 -> mag_init reaches 0xD1FE saturated (no overshoot), SETTLE0 one cycle later.
REQ-036 SHALL verify controls: realign from FAULT restarts RAMP at mag 0; calib_done drop in SETTLE1 -> IDLE, psi_offset retained; rst in SAMPLE1 -> all outputs 0.
